alu_issue: RTL and testbench
============================

Name: alu_issue

Overview:
- Execute-stage sequencer on the driving side of the ALU operand/result interface.
- Accepts one 32-bit RV32I OP/OP-IMM instruction per handshake and decodes it.
- Reads operands from an internal 32x32 register file, presents rs1/rs2/funct3/funct7 to the ALU, captures the ALU result and zero flag, and writes the result back.
- Rejects all other opcodes as illegal.

Parameters:
- ALU_LAT, 1, number of clk cycles ALU operands are held stable before the result is sampled (>=1).
- XLEN, 32, datapath width (fixed at 32 for RV32I).

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- instr_valid  in  1  instruction word valid
- instr_ready  out  1  unit can accept an instruction
- instr  in  32  RV32I instruction word
- alu_rs1  out  32  ALU operand A
- alu_rs2  out  32  ALU operand B (register or sign-extended immediate)
- alu_funct3  out  3  ALU operation select
- alu_funct7  out  1  ALU alternate-op select (SUB/SRA)
- alu_rd  in  32  ALU result
- alu_z  in  1  ALU zero flag
- wb_valid  out  1  one-cycle writeback strobe
- wb_addr  out  5  destination register index
- wb_data  out  32  writeback value
- zero  out  1  zero flag of the last completed instruction
- illegal  out  1  one-cycle pulse on a rejected instruction
- dbg_addr  in  5  debug register-file read index
- dbg_data  out  32  combinational register-file read (x0 reads 0)

Behaviour:
- Reset (async assert, sync release):
  - state=IDLE; all outputs 0 except instr_ready=1.
  - All 32 registers cleared.
  - An in-flight instruction is discarded with no writeback and no illegal pulse.
- FSM states: IDLE, EXEC, WB.
  - IDLE: instr_ready=1. When instr_valid&instr_ready at an edge, latch instr.
    - Legal instruction -> EXEC with counter=0.
    - Illegal instruction -> IDLE; illegal=1 for the following cycle.
  - EXEC (ALU_LAT cycles): instr_ready=0; alu_* driven from the latched instruction and stable throughout.
    - On the last EXEC edge, register alu_rd into wb_data and alu_z into zero -> WB.
  - WB (1 cycle): wb_valid=1, wb_addr=rd field.
    - The register file is written at the closing edge unless rd=0; x0 stays 0, wb_valid still pulses.
    - Then -> IDLE.
- Latency: accept edge to wb_valid = ALU_LAT+1 cycles. Throughput: one instruction per ALU_LAT+2 cycles.
- alu_* outputs in IDLE/WB: hold last values (don't-care to the ALU).
- Decode:
  - opcode 0110011 (OP): alu_rs2=x[rs2].
    - instr[31:25] must be 0000000, or 0100000 only with funct3 000 or 101; otherwise illegal.
    - alu_funct7=instr[30].
  - opcode 0010011 (OP-IMM): alu_rs2=sign-extend(instr[31:20]).
    - funct3 001 requires instr[31:25]=0.
    - funct3 101 requires instr[31:25] to be 0000000 or 0100000.
    - alu_funct7=instr[30] only for funct3 101; 0 for every other funct3 (ADDI with a negative immediate is never SUB).
  - alu_funct3=instr[14:12]; alu_rs1=x[rs1].
  - Any other opcode, or instr[1:0]!=11: illegal.
- Register-file reads occur in EXEC, so a writeback from the previous instruction is always visible; no forwarding is needed.
- instr_valid while instr_ready=0 is ignored. The producer holds instr until accepted.
- dbg_data reflects a WB write from the edge after that write.

Test Plan:
- Reset, then ADDI x1,x0,20 (0x01400093), then ADDI x2,x0,30 (0x01E00113) -> wb_valid with wb_addr=1/wb_data=20, then wb_addr=2/wb_data=30; each wb_valid comes exactly 2 cycles after accept (ALU_LAT=1).
- ADD x3,x1,x2 (0x002081B3) -> wb_data=50, zero=0; dbg_addr=3 reads 50.
- SUB x4,x1,x1 (0x40108233) -> wb_data=0, zero=1. ADDI x5,x0,-16 (0xFF000293) -> 0xFFFFFFF0 with alu_funct7=0.
- SRAI x6,x5,2 (0x4022D313) -> alu_funct7=1, alu_rs2=0x402, wb_data=0xFFFFFFFC.
- JAL (0x0000006F) and OP with funct7=0000001 (0x022081B3) -> illegal pulses for 1 cycle each, no wb_valid, x3 unchanged at 50.
- instr_valid held high across 3 instructions -> instr_ready low during EXEC/WB and each instruction accepted exactly once.
- rst_n asserted mid-EXEC of ADD x7,x1,x2 -> no wb_valid, and all registers read 0 after release.

Source files
------------

// File: rtl/alu_issue.sv
`default_nettype none
// ============================================================================
// Module   : alu_issue
// Summary  : RV32I OP/OP-IMM execute sequencer that drives an external ALU
//            and writes the ALU result back into its own 32x32 register file.
// Revision : 1.0
// ============================================================================
module alu_issue #(
  parameter int ALU_LAT = 1,
  parameter int XLEN    = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            instr_valid,
  output logic            instr_ready,
  input  logic [31:0]     instr,
  output logic [XLEN-1:0] alu_rs1,
  output logic [XLEN-1:0] alu_rs2,
  output logic [2:0]      alu_funct3,
  output logic            alu_funct7,
  input  logic [XLEN-1:0] alu_rd,
  input  logic            alu_z,
  output logic            wb_valid,
  output logic [4:0]      wb_addr,
  output logic [XLEN-1:0] wb_data,
  output logic            zero,
  output logic            illegal,
  input  logic [4:0]      dbg_addr,
  output logic [XLEN-1:0] dbg_data
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_WB   = 2'd2
  } state_t;

  localparam logic [6:0]      c_op_reg   = 7'b0110011;
  localparam logic [6:0]      c_op_imm   = 7'b0010011;
  localparam logic [6:0]      c_f7_alt   = 7'b0100000;
  localparam int              c_cw       = (ALU_LAT > 1) ? $clog2(ALU_LAT) : 1;
  localparam logic [c_cw-1:0] c_cnt_last = c_cw'(ALU_LAT - 1);

  state_t            r_state;
  state_t            w_state_nxt;
  logic [31:0]       r_instr;
  logic [c_cw-1:0]   r_cnt;
  logic [XLEN-1:0]   r_rf [32];
  logic [XLEN-1:0]   r_wb_data;
  logic              r_zero;
  logic              r_illegal;
  logic              w_accept;
  logic              w_legal;
  logic              w_last;
  logic [6:0]        w_in_f7;
  logic [2:0]        w_in_f3;
  logic [6:0]        w_op;

  assign w_in_f7  = instr[31:25];
  assign w_in_f3  = instr[14:12];
  assign w_accept = instr_valid && (r_state == S_IDLE);
  assign w_last   = (r_cnt == c_cnt_last);

  // Decode of the incoming word; only OP and OP-IMM encodings are accepted.
  always_comb begin
    w_legal = 1'b0;
    case (instr[6:0])
      c_op_reg: w_legal = (w_in_f7 == 7'd0) ||
                          ((w_in_f7 == c_f7_alt) && ((w_in_f3 == 3'b000) || (w_in_f3 == 3'b101)));
      c_op_imm: begin
        case (w_in_f3)
          3'b001:  w_legal = (w_in_f7 == 7'd0);
          3'b101:  w_legal = (w_in_f7 == 7'd0) || (w_in_f7 == c_f7_alt);
          default: w_legal = 1'b1;
        endcase
      end
      default:  w_legal = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    instr_ready = 1'b0;
    wb_valid    = 1'b0;
    case (r_state)
      S_IDLE: begin
        instr_ready = 1'b1;
        if (instr_valid) begin
          w_state_nxt = w_legal ? S_EXEC : S_IDLE;
        end
      end
      S_EXEC: begin
        if (w_last) begin
          w_state_nxt = S_WB;
        end
      end
      S_WB: begin
        wb_valid    = 1'b1;
        w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_instr   <= '0;
      r_cnt     <= '0;
      r_wb_data <= '0;
      r_zero    <= 1'b0;
      r_illegal <= 1'b0;
      for (int i = 0; i < 32; i++) begin
        r_rf[i] <= '0;
      end
    end else begin
      r_illegal <= w_accept && !w_legal;
      if (w_accept) begin
        r_instr <= instr;
        r_cnt   <= '0;
      end
      if (r_state == S_EXEC) begin
        r_cnt <= r_cnt + 1'b1;
        if (w_last) begin
          r_wb_data <= alu_rd;
          r_zero    <= alu_z;
        end
      end
      // Entry 0 is never written, so it reads as zero everywhere.
      if ((r_state == S_WB) && (r_instr[11:7] != 5'd0)) begin
        r_rf[r_instr[11:7]] <= r_wb_data;
      end
    end
  end

  assign w_op       = r_instr[6:0];
  assign alu_rs1    = r_rf[r_instr[19:15]];
  assign alu_rs2    = (w_op == c_op_imm) ? {{(XLEN-12){r_instr[31]}}, r_instr[31:20]}
                                         : r_rf[r_instr[24:20]];
  assign alu_funct3 = r_instr[14:12];
  // Only register ops and immediate right shifts carry the alternate-op bit.
  assign alu_funct7 = ((w_op == c_op_reg) ||
                       ((w_op == c_op_imm) && (r_instr[14:12] == 3'b101))) ? r_instr[30] : 1'b0;

  assign wb_addr  = r_instr[11:7];
  assign wb_data  = r_wb_data;
  assign zero     = r_zero;
  assign illegal  = r_illegal;
  assign dbg_data = (dbg_addr == 5'd0) ? '0 : r_rf[dbg_addr];

endmodule
`default_nettype wire

// File: tb/tb_alu_issue.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_issue
// Summary  : Directed self-checking bench for alu_issue with a behavioural ALU.
// Revision : 1.0
// ============================================================================
module tb_alu_issue;

  logic        clk;
  logic        rst_n;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr;
  logic [31:0] alu_rs1;
  logic [31:0] alu_rs2;
  logic [2:0]  alu_funct3;
  logic        alu_funct7;
  logic [31:0] alu_rd;
  logic        alu_z;
  logic        wb_valid;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;
  logic        zero;
  logic        illegal;
  logic [4:0]  dbg_addr;
  logic [31:0] dbg_data;

  int          n_checks;
  int          n_errors;
  int          wb_cnt;
  int          acc_cnt;
  int          ready_viol;
  logic [31:0] cap_rs2;
  logic        cap_f7;

  alu_issue #(.ALU_LAT(1), .XLEN(32)) u_dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .instr       (instr),
    .alu_rs1     (alu_rs1),
    .alu_rs2     (alu_rs2),
    .alu_funct3  (alu_funct3),
    .alu_funct7  (alu_funct7),
    .alu_rd      (alu_rd),
    .alu_z       (alu_z),
    .wb_valid    (wb_valid),
    .wb_addr     (wb_addr),
    .wb_data     (wb_data),
    .zero        (zero),
    .illegal     (illegal),
    .dbg_addr    (dbg_addr),
    .dbg_data    (dbg_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural ALU on the far side of the operand/result interface.
  always_comb begin
    case (alu_funct3)
      3'd0:    alu_rd = alu_funct7 ? (alu_rs1 - alu_rs2) : (alu_rs1 + alu_rs2);
      3'd1:    alu_rd = alu_rs1 << alu_rs2[4:0];
      3'd2:    alu_rd = {31'd0, $signed(alu_rs1) < $signed(alu_rs2)};
      3'd3:    alu_rd = {31'd0, alu_rs1 < alu_rs2};
      3'd4:    alu_rd = alu_rs1 ^ alu_rs2;
      3'd5:    alu_rd = alu_funct7 ? 32'($signed(alu_rs1) >>> alu_rs2[4:0]) : (alu_rs1 >> alu_rs2[4:0]);
      3'd6:    alu_rd = alu_rs1 | alu_rs2;
      default: alu_rd = alu_rs1 & alu_rs2;
    endcase
    alu_z = (alu_rd == 32'd0);
  end

  always @(negedge clk) begin
    if (wb_valid) wb_cnt++;
    if (instr_valid && instr_ready) acc_cnt++;
    if (wb_valid && instr_ready) ready_viol++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Inputs change 1 ns after a rising edge; outputs are sampled on falling edges.
  task automatic issue(input string tag, input logic [31:0] ins, input logic legal,
                       input logic [4:0] rd, input logic [31:0] data, input logic zf);
    int n;
    int wb0;
    @(posedge clk); #1;
    instr       = ins;
    instr_valid = 1'b1;
    @(negedge clk);
    check({tag, ".ready"}, {31'd0, instr_ready}, 32'd1);
    wb0 = wb_cnt;
    @(posedge clk); #1;
    instr_valid = 1'b0;
    @(negedge clk);
    if (legal) begin
      cap_rs2 = alu_rs2;
      cap_f7  = alu_funct7;
      check({tag, ".busy"}, {31'd0, instr_ready}, 32'd0);
      n = 1;
      while (wb_valid !== 1'b1 && n < 20) begin
        @(negedge clk);
        n++;
      end
      check({tag, ".latency"}, n, 32'd2);
      check({tag, ".wb_addr"}, {27'd0, wb_addr}, {27'd0, rd});
      check({tag, ".wb_data"}, wb_data, data);
      check({tag, ".zero"}, {31'd0, zero}, {31'd0, zf});
      @(negedge clk);
      check({tag, ".wb_end"}, {31'd0, wb_valid}, 32'd0);
    end else begin
      check({tag, ".illegal"}, {31'd0, illegal}, 32'd1);
      check({tag, ".idle"}, {31'd0, instr_ready}, 32'd1);
      @(negedge clk);
      check({tag, ".illegal_end"}, {31'd0, illegal}, 32'd0);
      check({tag, ".no_wb"}, wb_cnt - wb0, 32'd0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running, expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] seq [3];
    int          n;
    int          wb0;
    int          acc0;
    n_checks    = 0;
    n_errors    = 0;
    wb_cnt      = 0;
    acc_cnt     = 0;
    ready_viol  = 0;
    rst_n       = 1'b0;
    instr_valid = 1'b0;
    instr       = 32'd0;
    dbg_addr    = 5'd0;

    repeat (2) @(negedge clk);
    check("rst.ready", {31'd0, instr_ready}, 32'd1);
    check("rst.wb_valid", {31'd0, wb_valid}, 32'd0);
    check("rst.illegal", {31'd0, illegal}, 32'd0);
    check("rst.zero", {31'd0, zero}, 32'd0);
    check("rst.wb_data", wb_data, 32'd0);
    check("rst.wb_addr", {27'd0, wb_addr}, 32'd0);
    check("rst.alu_rs1", alu_rs1, 32'd0);
    check("rst.alu_rs2", alu_rs2, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    issue("addi_x1", 32'h01400093, 1'b1, 5'd1, 32'd20, 1'b0);
    issue("addi_x2", 32'h01E00113, 1'b1, 5'd2, 32'd30, 1'b0);
    issue("add_x3",  32'h002081B3, 1'b1, 5'd3, 32'd50, 1'b0);
    dbg_addr = 5'd3; #1;
    check("dbg.x3", dbg_data, 32'd50);
    issue("sub_x4",  32'h40108233, 1'b1, 5'd4, 32'd0, 1'b1);
    check("sub.funct7", {31'd0, cap_f7}, 32'd1);
    issue("addi_neg", 32'hFF000293, 1'b1, 5'd5, 32'hFFFFFFF0, 1'b0);
    check("addi_neg.funct7", {31'd0, cap_f7}, 32'd0);
    check("addi_neg.rs2", cap_rs2, 32'hFFFFFFF0);
    issue("srai_x6", 32'h4022D313, 1'b1, 5'd6, 32'hFFFFFFFC, 1'b0);
    check("srai.funct7", {31'd0, cap_f7}, 32'd1);
    check("srai.rs2", cap_rs2, 32'h00000402);

    issue("jal", 32'h0000006F, 1'b0, 5'd0, 32'd0, 1'b0);
    issue("op_f7", 32'h022081B3, 1'b0, 5'd0, 32'd0, 1'b0);
    issue("slli_f7", 32'h40009093, 1'b0, 5'd0, 32'd0, 1'b0);
    dbg_addr = 5'd3; #1;
    check("dbg.x3_kept", dbg_data, 32'd50);
    dbg_addr = 5'd1; #1;
    check("dbg.x1_kept", dbg_data, 32'd20);

    // A write to x0 still strobes, but a later read of x0 must see zero.
    issue("addi_x0", 32'h00500013, 1'b1, 5'd0, 32'd5, 1'b0);
    issue("add_x0x0", 32'h000005B3, 1'b1, 5'd11, 32'd0, 1'b1);

    seq[0] = 32'h00100413;
    seq[1] = 32'h00200493;
    seq[2] = 32'h00940533;
    @(posedge clk); #1;
    wb0  = wb_cnt;
    acc0 = acc_cnt;
    instr_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      instr = seq[k];
      n = 0;
      @(negedge clk);
      while (!instr_ready && n < 20) begin
        @(negedge clk);
        n++;
      end
      check($sformatf("b2b.ready%0d", k), {31'd0, instr_ready}, 32'd1);
      @(posedge clk); #1;
    end
    instr_valid = 1'b0;
    repeat (4) @(negedge clk);
    check("b2b.accepts", acc_cnt - acc0, 32'd3);
    check("b2b.writebacks", wb_cnt - wb0, 32'd3);
    check("b2b.ready_in_wb", ready_viol, 32'd0);
    dbg_addr = 5'd10; #1;
    check("b2b.x10", dbg_data, 32'd3);
    dbg_addr = 5'd8; #1;
    check("b2b.x8", dbg_data, 32'd1);

    @(posedge clk); #1;
    instr       = 32'h002083B3;
    instr_valid = 1'b1;
    @(posedge clk); #1;
    instr_valid = 1'b0;
    wb0 = wb_cnt;
    @(negedge clk);
    check("rstmid.busy", {31'd0, instr_ready}, 32'd0);
    rst_n = 1'b0;
    #1;
    check("rstmid.ready", {31'd0, instr_ready}, 32'd1);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check("rstmid.no_wb", wb_cnt - wb0, 32'd0);
    check("rstmid.illegal", {31'd0, illegal}, 32'd0);
    for (int i = 0; i < 32; i++) begin
      dbg_addr = 5'(i);
      #1;
      check($sformatf("rstmid.x%0d", i), dbg_data, 32'd0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
